dma_controller: RTL

Byte-copy engine that sits beside the CPU on the 8-bit memory-mapped bus. It copies LEN bytes from SRC to DST, either memory-to-memory or memory-to-peripheral, for example RAM into the UART transmit register. The CPU programs it through a 4-register IO window decoded by the memory controller's regSelect. While copying, it masters the same Address/WriteData/writeEnable bus through a request/grant handshake with the bus mux.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_regs.sv | 64 ++++++
 rtl/dma_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared states, register indices and CTRL/STATUS bit positions for the DMA engine
package dma_pkg;
    typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_t;
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;
    localparam int CTRL_START      = 0;
    localparam int STAT_BUSY       = 1;
    localparam int STAT_DONE       = 2;
    localparam int CTRL_DST_FIXED  = 3;
    localparam int CTRL_SRC_FIXED  = 4;
    localparam int CTRL_ABORT      = 5;
    localparam int CTRL_CLEAR_DONE = 6;
    localparam int STAT_ABORTED    = 7;
endpackage

// File: rtl/dma_regs.sv
// dma_regs: CPU register window decode, control/status flags and readback mux
module dma_regs
    import dma_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cfgWriteEnable,
    input  logic       cfgReadEnable,
    input  logic [1:0] regSelect,
    input  logic [7:0] cfgWriteData,
    input  logic       busy,
    input  logic       set_done,
    input  logic       set_aborted,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    output logic [7:0] cfgData,
    output logic       wr_src,
    output logic       wr_dst,
    output logic       wr_len,
    output logic       start,
    output logic       abort,
    output logic       dst_fixed,
    output logic       src_fixed,
    output logic       done
);
    logic aborted, wr_ctrl, clear;
    logic [7:0] status;
    always_comb begin
        wr_ctrl = cfgWriteEnable && regSelect == REG_CTRL;
        wr_src = cfgWriteEnable && regSelect == REG_SRC && !busy;
        wr_dst = cfgWriteEnable && regSelect == REG_DST && !busy;
        wr_len = cfgWriteEnable && regSelect == REG_LEN && !busy;
        start = wr_ctrl && cfgWriteData[CTRL_START] && !cfgWriteData[CTRL_ABORT] && !busy;
        abort = wr_ctrl && cfgWriteData[CTRL_ABORT];
        clear = wr_ctrl && cfgWriteData[CTRL_CLEAR_DONE];
        status = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done;
        status[CTRL_DST_FIXED] = dst_fixed;
        status[CTRL_SRC_FIXED] = src_fixed;
        status[STAT_ABORTED] = aborted;
        cfgData = !cfgReadEnable ? 8'h00 :
                  regSelect == REG_SRC ? src :
                  regSelect == REG_DST ? dst :
                  regSelect == REG_LEN ? len : status;
    end
    // a completion or abort in the same cycle as clearDone takes precedence
    always_ff @(posedge clk) begin
        if (!reset) begin
            dst_fixed <= 1'b0;
            src_fixed <= 1'b0;
            done <= 1'b0;
            aborted <= 1'b0;
        end else begin
            if (wr_ctrl && !busy) begin
                dst_fixed <= cfgWriteData[CTRL_DST_FIXED];
                src_fixed <= cfgWriteData[CTRL_SRC_FIXED];
            end
            done <= set_done || (done && !clear);
            aborted <= set_aborted || (aborted && !clear);
        end
    end
endmodule

// File: rtl/dma_controller.sv
// dma_controller: byte-copy bus master with request/grant handshake and destination pacing
module dma_controller
    import dma_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfgWriteEnable,
    input  logic       cfgReadEnable,
    input  logic [1:0] regSelect,
    input  logic [7:0] cfgWriteData,
    output logic [7:0] cfgData,
    output logic       busReq,
    input  logic       busGrant,
    output logic [7:0] Address,
    output logic [7:0] WriteData,
    output logic       writeEnable,
    input  logic [7:0] Data,
    input  logic       paceReady,
    output logic       irq
);
    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);
    state_t state;
    logic [7:0] src, dst, len;
    logic [1:0] lat;
    logic wr_src, wr_dst, wr_len, start, abort, dst_fixed, src_fixed, done;
    logic busy, set_done, set_aborted;
    always_comb begin
        busy = state != IDLE;
        set_aborted = abort && busy;
        set_done = !set_aborted && ((!busy && start && len == 8'd0) || (state == REL && len == 8'd1));
        irq = done;
    end
    dma_regs u_regs (
        .clk(clk),
        .reset(reset),
        .cfgWriteEnable(cfgWriteEnable),
        .cfgReadEnable(cfgReadEnable),
        .regSelect(regSelect),
        .cfgWriteData(cfgWriteData),
        .busy(busy),
        .set_done(set_done),
        .set_aborted(set_aborted),
        .src(src),
        .dst(dst),
        .len(len),
        .cfgData(cfgData),
        .wr_src(wr_src),
        .wr_dst(wr_dst),
        .wr_len(wr_len),
        .start(start),
        .abort(abort),
        .dst_fixed(dst_fixed),
        .src_fixed(src_fixed),
        .done(done)
    );
    // WriteData doubles as the byte buffer; writeEnable is armed from paceReady seen at the previous edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busReq <= 1'b0;
            writeEnable <= 1'b0;
            Address <= '0;
            WriteData <= '0;
            src <= '0;
            dst <= '0;
            len <= '0;
            lat <= '0;
        end else if (set_aborted) begin
            state <= IDLE;
            busReq <= 1'b0;
            writeEnable <= 1'b0;
            Address <= '0;
        end else begin
            if (wr_src) src <= cfgWriteData;
            if (wr_dst) dst <= cfgWriteData;
            if (wr_len) len <= cfgWriteData;
            case (state)
                IDLE: if (start && len != 8'd0) begin
                    state <= REQ;
                    busReq <= 1'b1;
                end
                REQ: if (busGrant) begin
                    state <= RD;
                    Address <= src;
                    lat <= '0;
                end
                RD: if (lat == LAT_LAST) begin
                    state <= WR;
                    WriteData <= Data;
                    Address <= dst;
                    writeEnable <= paceReady;
                end else lat <= lat + 2'd1;
                WR: if (writeEnable) begin
                    state <= REL;
                    writeEnable <= 1'b0;
                    busReq <= 1'b0;
                    Address <= '0;
                end else writeEnable <= paceReady;
                REL: begin
                    len <= len - 8'd1;
                    src <= src_fixed ? src : src + 8'd1;
                    dst <= dst_fixed ? dst : dst + 8'd1;
                    state <= len == 8'd1 ? IDLE : REQ;
                    busReq <= len != 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
